// File: rtl/argmax_stream.sv
// Purpose : streaming argmax over LAYER_SZ signed activations, LANES values per beat.
// Latency : out_valid rises the cycle after the last beat is accepted (BEATS+1 cycles/vector).
// Backpress: in_ready drops while a result is held; the result is held until out_ready.
// Ports   : clk/rst (sync, active-high); in_valid/in_ready/in_data input beats,
//           lane j = in_data[j*SIZE +: SIZE] is class beat*LANES+j;
//           out_valid/out_ready/class_out/max_out result (class_out all ones = no class).
module argmax_stream #(
    parameter int SIZE     = 16,
    parameter int LAYER_SZ = 2,
    parameter int LANES    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*SIZE-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SIZE-1:0]       class_out,
    output logic [SIZE-1:0]       max_out
);
    localparam int BEATS = LAYER_SZ / LANES;
    localparam int IW    = (LAYER_SZ > 1) ? $clog2(LAYER_SZ) : 1;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_DONE  = 1'b1;

    localparam logic [SIZE-1:0] SIZE_MIN = {1'b1, {(SIZE-1){1'b0}}};

    logic [0:0]             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic signed [SIZE-1:0] max_q, max_d;
    logic [IW-1:0]          idx_q, idx_d;
    // The IW-bit index can legally be all ones (e.g. class 3 of 4), so a
    // separate flag records whether any lane has won yet; it selects between
    // the zero-extended index and the SIZE-wide all-ones sentinel.
    logic                   hit_q, hit_d;
    logic [SIZE-1:0]        class_q, class_d;
    logic [SIZE-1:0]        maxo_q, maxo_d;

    // Per-beat lane scan result (running max folded with this beat's lanes).
    logic signed [SIZE-1:0] beat_max;
    logic [IW-1:0]          beat_idx;
    logic                   beat_hit;
    logic [SIZE-1:0]        lane_val;
    logic [31:0]            lane_idx;

    logic accept;
    logic last_beat;

    assign in_ready  = (state_q == ST_ACCUM);
    assign out_valid = (state_q == ST_DONE);
    assign class_out = class_q;
    assign max_out   = maxo_q;

    assign accept    = in_valid && in_ready;
    assign last_beat = (cnt_q == CW'(BEATS - 1));

    // Ascending lane order with a strict '>' keeps the lowest index on ties,
    // both within a beat and against earlier beats.
    always_comb begin
        beat_max = max_q;
        beat_idx = idx_q;
        beat_hit = hit_q;
        lane_val = '0;
        lane_idx = '0;
        for (int j = 0; j < LANES; j++) begin
            lane_val = in_data[j*SIZE +: SIZE];
            lane_idx = 32'(cnt_q) * 32'(LANES) + 32'(j);
            if ($signed(lane_val) > beat_max) begin
                beat_max = $signed(lane_val);
                beat_idx = lane_idx[IW-1:0];
                beat_hit = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        max_d   = max_q;
        idx_d   = idx_q;
        hit_d   = hit_q;
        class_d = class_q;
        maxo_d  = maxo_q;
        case (state_q)
            ST_ACCUM: begin
                if (accept) begin
                    max_d = beat_max;
                    idx_d = beat_idx;
                    hit_d = beat_hit;
                    if (last_beat) begin
                        cnt_d   = '0;
                        class_d = beat_hit ? SIZE'(beat_idx) : '1;
                        maxo_d  = beat_max;
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                // Result stays registered after release; only the running
                // scan is re-armed so no stale max leaks into the next vector.
                if (out_ready) begin
                    state_d = ST_ACCUM;
                    max_d   = $signed(SIZE_MIN);
                    idx_d   = '1;
                    hit_d   = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ACCUM;
            cnt_q   <= '0;
            max_q   <= $signed(SIZE_MIN);
            idx_q   <= '1;
            hit_q   <= 1'b0;
            class_q <= '1;
            maxo_q  <= SIZE_MIN;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            max_q   <= max_d;
            idx_q   <= idx_d;
            hit_q   <= hit_d;
            class_q <= class_d;
            maxo_q  <= maxo_d;
        end
    end

endmodule
